// File: rtl/delay_initiator_pkg.sv
// Shared types and constants for the delay-counter requester: state encoding,
// default data width and the all-ones pattern that marks a finished count.
package delay_pkg;

    localparam int DW_DEF = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        CHECK = 3'd3,
        HALT  = 3'd4
    } dinit_state_t;

    localparam logic [DW_DEF-1:0] DONE_ALL_ONES = '1;

endpackage

// File: rtl/delay_initiator_if.sv
// Bundle of the request queue, delay-counter and response signals of the
// delay requester. The slave modport is the requester, the master its environment.
interface delay_initiator_if #(
    parameter int DW = 32
);
    // Requests transfer on a rising edge when req_valid && req_ready; req_delay
    // must hold while req_valid is high. rsp_valid is a 1-cycle pulse, no back-pressure.
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_delay;
    logic          dly_start;
    logic [DW-1:0] dly_value;
    logic [DW-1:0] dly_done;
    logic          rsp_valid;
    logic          rsp_err;

    modport master (
        output req_valid, req_delay, dly_done,
        input  req_ready, dly_start, dly_value, rsp_valid, rsp_err
    );

    modport slave (
        input  req_valid, req_delay, dly_done,
        output req_ready, dly_start, dly_value, rsp_valid, rsp_err
    );

endinterface

// File: rtl/delay_initiator_req_fifo.sv
// Synchronous request buffer, DW bits by DEPTH entries, with full/empty flags.
// DEPTH must be a power of two; pointers carry one extra wrap bit.
module delay_req_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/delay_initiator.sv
// Requester for a reset-less delay counter: holds dly_start for value+1 cycles,
// checks dly_done for early and final completion, returns one pass/fail per request.
module delay_initiator
    import delay_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int FIFO_DEPTH  = 4,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    delay_initiator_if.slave   bus,
    output logic               busy_o,
    output logic [7:0]         err_count_o,
    output dinit_state_t       state_o
);

    dinit_state_t  state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] value_q, value_d;
    logic          start_q, start_d;
    logic          sticky_q, sticky_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic [DW-1:0] fifo_head;
    logic          check_fail;

    delay_req_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.req_valid && bus.req_ready),
        .din_i   (bus.req_delay),
        .pop_i   (state_q == LOAD),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign check_fail = sticky_q || (bus.dly_done != DONE_ALL_ONES[DW-1:0]);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        value_d     = value_q;
        start_d     = start_q;
        sticky_d    = sticky_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = LOAD;
            end
            LOAD: begin
                value_d  = fifo_head;
                start_d  = 1'b1;
                cnt_d    = '0;
                sticky_d = 1'b0;
                state_d  = RUN;
            end
            RUN: begin
                // cnt==0 sees the done value left from before start rose.
                if (cnt_q != '0 && bus.dly_done != '0) sticky_d = 1'b1;
                if (cnt_q == value_q) begin
                    start_d = 1'b0;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            CHECK: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = check_fail;
                if (check_fail && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                state_d = (check_fail && STOP_ON_ERR) ? HALT : IDLE;
            end
            HALT: begin
                start_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            value_q     <= '0;
            start_q     <= 1'b0;
            sticky_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            value_q     <= value_d;
            start_q     <= start_d;
            sticky_q    <= sticky_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.req_ready = !fifo_full && (state_q != HALT);
    assign bus.dly_start = start_q;
    assign bus.dly_value = value_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy_o        = (state_q != IDLE) || !fifo_empty;
    assign err_count_o   = err_cnt_q;
    assign state_o       = state_q;

endmodule
